// File: rtl/fetch_unit.sv
// fetch_unit: PC register and instruction fetch stage of the RV64 core.
// Fetches over a req/resp handshake and computes the next PC on retire.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000000000000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    input  logic        retire,
    input  logic [1:0]  pc_sel,
    input  logic [63:0] imm,
    input  logic [63:0] rs1_data,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_TRAP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] target;
    logic [63:0] jalr_sum;
    logic        misaligned;
    logic        accept;
    logic        load_instr;
    logic        do_retire;

    assign imem_addr  = pc;
    assign pc_plus4   = pc + 64'd4;
    assign accept     = imem_req & imem_ready;
    assign load_instr = (state_q == S_WAIT) & imem_rvalid;
    assign do_retire  = (state_q == S_EXEC) & retire;

    // Next-PC target selection and alignment check
    always_comb begin
        jalr_sum = rs1_data + imm;
        target   = pc_plus4;
        case (pc_sel)
            2'b01:   target = pc + imm;
            2'b10:   target = {jalr_sum[63:1], 1'b0};
            default: target = pc_plus4;
        endcase
        misaligned = (target[1:0] != 2'b00);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (accept) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = S_EXEC;
            S_EXEC: begin
                if (retire) state_d = misaligned ? S_TRAP : S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request is raised one cycle into FETCH and held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) imem_req <= 1'b0;
        else        imem_req <= (state_q == S_FETCH) & ~accept;
    end

    // PC loads only on an aligned retire; a faulting target leaves it put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       pc <= RESET_PC;
        else if (do_retire & ~misaligned) pc <= target;
    end

    // Instruction capture from memory, cleared back to NOP on retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (load_instr) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
        end else if (do_retire) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

    // Sticky misaligned-target trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      trap <= 1'b0;
        else if (do_retire & misaligned) trap <= 1'b1;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit
// against a transaction-level model of the fetch/retire rules.
module tb_fetch_unit;

    localparam logic [63:0] RST = 64'h0;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        retire;
    logic [1:0]  pc_sel;
    logic [63:0] imm;
    logic [63:0] rs1_data;
    logic        trap;

    int checks = 0;
    int errors = 0;

    logic        rand_mode = 1'b0;
    logic        dir_ready = 1'b1;
    int          dir_lat   = 0;
    logic [31:0] dir_data  = NOP;
    logic        dir_spur  = 1'b0;
    logic        dir_go    = 1'b0;
    logic [1:0]  dir_sel   = 2'd0;
    logic [63:0] dir_imm   = 64'd0;
    logic [63:0] dir_rs1   = 64'd0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .pc_sel      (pc_sel),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_target(input logic [1:0] s,
        input logic [63:0] p, input logic [63:0] i, input logic [63:0] r);
        logic [63:0] t;
        if (s == 2'd1) t = p + i;
        else if (s == 2'd2) begin
            t = r + i;
            t = t - (t % 2);
        end else t = p + 64'd4;
        return t;
    endfunction

    // Reference model: what the unit must hold after each edge
    logic [63:0] m_pc;
    logic [63:0] mt;
    logic [31:0] m_instr;
    logic        m_valid, m_req, m_trap, m_wait;
    logic [1:0]  m_dly;

    assign mt = model_target(pc_sel, m_pc, imm, rs1_data);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= RST;
            m_instr <= NOP;
            m_valid <= 1'b0;
            m_req   <= 1'b0;
            m_trap  <= 1'b0;
            m_wait  <= 1'b0;
            m_dly   <= 2'd2;
        end else begin
            if (m_dly == 2'd1) m_req <= 1'b1;
            if (m_dly != 2'd0) m_dly <= m_dly - 2'd1;
            if (m_req && imem_ready) begin
                m_req  <= 1'b0;
                m_wait <= 1'b1;
            end
            if (m_wait && imem_rvalid) begin
                m_wait  <= 1'b0;
                m_instr <= imem_rdata;
                m_valid <= 1'b1;
            end
            if (m_valid && retire) begin
                m_valid <= 1'b0;
                m_instr <= NOP;
                if (mt % 4 != 0) m_trap <= 1'b1;
                else begin
                    m_pc  <= mt;
                    m_dly <= 2'd1;
                end
            end
        end
    end

    // Compare process: every cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 64'd4);
            chk("instruction", {32'd0, instruction}, {32'd0, m_instr});
            chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_valid});
            chk("imem_req", {63'd0, imem_req}, {63'd0, m_req});
            chk("trap", {63'd0, trap}, {63'd0, m_trap});
        end
    end

    // Stimulus driver: memory responder and retire inputs
    initial begin
        logic armed;
        int   lat_cnt;
        armed       = 1'b0;
        lat_cnt     = 0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        retire      = 1'b0;
        pc_sel      = 2'd0;
        imm         = 64'd0;
        rs1_data    = 64'd0;
        forever begin
            @(negedge clk);
            if (m_wait) begin
                if (!armed) begin
                    armed   = 1'b1;
                    lat_cnt = rand_mode ? int'($urandom_range(0, 2)) : dir_lat;
                end
                if (lat_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rand_mode ? $urandom : dir_data;
                end else begin
                    lat_cnt--;
                    imem_rvalid = 1'b0;
                end
            end else begin
                armed       = 1'b0;
                imem_rvalid = rand_mode ? ($urandom % 4 == 0) : dir_spur;
                imem_rdata  = 32'hDEADBEEF;
            end
            if (rand_mode) begin
                imem_ready = ($urandom % 3 != 0);
                retire     = ($urandom % 3 == 0);
                pc_sel     = 2'($urandom);
                if ($urandom % 16 == 0) imm = {$urandom, $urandom};
                else imm = 64'($urandom_range(0, 4095)) * 64'd4 - 64'd8192;
                rs1_data = ({$urandom, $urandom} & ~64'h3) | 64'($urandom % 2);
                if ($urandom % 10 == 0) rs1_data = rs1_data | 64'h2;
            end else begin
                imem_ready = dir_ready;
                retire     = dir_go;
                pc_sel     = dir_sel;
                imm        = dir_imm;
                rs1_data   = dir_rs1;
            end
        end
    end

    task automatic wait_req();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = imem_req;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req timeout at %0t", $time);
        end
    endtask

    task automatic wait_valid();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = instr_valid;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid timeout at %0t", $time);
        end
    endtask

    task automatic retire_with(input logic [1:0] s, input logic [63:0] i,
                               input logic [63:0] r);
        wait_valid();
        dir_sel = s;
        dir_imm = i;
        dir_rs1 = r;
        @(posedge clk);
        dir_go = 1'b1;
        @(posedge clk);
        dir_go = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   tc;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", pc, 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_plus4", pc_plus4, 64'h4);
        chk("rst_instr", {32'd0, instruction}, 64'h13);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_trap", {63'd0, trap}, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("req_edge1", {63'd0, imem_req}, 64'd0);
        @(posedge clk);
        #1 chk("req_edge2", {63'd0, imem_req}, 64'd1);

        for (int i = 0; i < 4; i++) begin
            wait_req();
            chk("seq_addr", imem_addr, 64'(i * 4));
            if (i == 0) begin
                @(posedge clk);
                #1 chk("valid_n0", {63'd0, instr_valid}, 64'd0);
                @(posedge clk);
                #1 chk("valid_n1", {63'd0, instr_valid}, 64'd1);
            end
            retire_with(2'd0, 64'd0, 64'd0);
        end

        dir_ready = 1'b0;
        dir_data  = 32'h00100093;
        dir_spur  = 1'b1;
        wait_req();
        chk("bp_addr", imem_addr, 64'h10);
        repeat (5) begin
            @(negedge clk);
            chk("bp_req", {63'd0, imem_req}, 64'd1);
            chk("bp_addr_hold", imem_addr, 64'h10);
            chk("bp_instr", {32'd0, instruction}, 64'h13);
        end
        dir_ready = 1'b1;
        wait_valid();
        chk("exec_instr", {32'd0, instruction}, 64'h00100093);
        repeat (3) @(negedge clk);
        chk("exec_instr_spur", {32'd0, instruction}, 64'h00100093);

        retire_with(2'd2, 64'd0, 64'h100);
        wait_req();
        chk("jalr_100", imem_addr, 64'h100);
        retire_with(2'd1, 64'hFFFFFFFFFFFFFFFC, 64'd0);
        wait_req();
        chk("br_back", imem_addr, 64'hFC);
        retire_with(2'd1, 64'd2048, 64'd0);
        wait_req();
        chk("br_fwd", imem_addr, 64'h8FC);

        dir_lat = 3;
        retire_with(2'd0, 64'd0, 64'd0);
        wait_req();
        chk("pre_wait", imem_addr, 64'h900);
        @(posedge clk);
        dir_sel = 2'd1;
        dir_imm = 64'h40;
        @(posedge clk);
        dir_go = 1'b1;
        @(posedge clk);
        dir_go = 1'b0;
        wait_valid();
        chk("wait_retire_ign", pc, 64'h900);
        retire_with(2'd0, 64'd0, 64'd0);
        wait_req();
        chk("after_wait", imem_addr, 64'h904);
        dir_lat = 0;

        retire_with(2'd2, 64'd0, 64'hFFFFFFFFFFFFFFFC);
        wait_req();
        chk("top_addr", imem_addr, 64'hFFFFFFFFFFFFFFFC);
        chk("top_plus4", pc_plus4, 64'h0);
        retire_with(2'd0, 64'd0, 64'd0);
        wait_req();
        chk("wrap_addr", imem_addr, 64'h0);

        retire_with(2'd2, 64'h1, 64'h1003);
        wait_req();
        chk("jalr_clr", imem_addr, 64'h1004);
        retire_with(2'd2, 64'h1, 64'h1001);
        @(negedge clk);
        @(negedge clk);
        chk("trap_set", {63'd0, trap}, 64'd1);
        chk("trap_pc", pc, 64'h1004);
        chk("trap_valid", {63'd0, instr_valid}, 64'd0);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw = saw | imem_req;
        end
        chk("trap_no_req", {63'd0, saw}, 64'd0);

        do_reset();
        wait_req();
        chk("restart0", imem_addr, 64'h0);
        retire_with(2'd0, 64'd0, 64'd0);
        wait_req();
        retire_with(2'd0, 64'd0, 64'd0);
        wait_req();
        chk("pre_rst_addr", imem_addr, 64'h8);
        dir_lat = 4;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 64'h0);
        chk("mid_rst_plus4", pc_plus4, 64'h4);
        chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
        chk("mid_rst_instr", {32'd0, instruction}, 64'h13);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_req();
        chk("late_rv_addr", imem_addr, 64'h0);
        chk("late_rv_valid", {63'd0, instr_valid}, 64'd0);
        chk("late_rv_instr", {32'd0, instruction}, 64'h13);
        dir_lat  = 0;
        dir_spur = 1'b0;

        do_reset();
        rand_mode = 1'b1;
        tc = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (m_trap) tc++;
            if (tc > 6 || $urandom % 500 == 0) begin
                tc = 0;
                do_reset();
            end
        end
        rand_mode = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
